// File: rtl/hex_scan_ctrl_pkg.sv
// Shared constants and state encoding for the multiplexed hex display scanner.
package hex_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex_scan_ctrl_decoder.sv
// Hex nibble to active-low seven-segment glyph, bit 0 = segment a.
module hex_decoder (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure lookup of the team's hex glyph table
  always_comb begin
    seg = 7'h7F;
    unique case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit hex display scanner: each digit is lit for DIV_COUNT cycles,
// followed by GUARD_CYCLES of blanking to avoid ghosting between digits.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int DIV_COUNT    = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [6:0] seg,
  output logic [3:0] digit_sel
);

  localparam int CW = $clog2(DIV_COUNT);
  localparam int GW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_RELOAD  = CW'(DIV_COUNT - 1);
  localparam logic [GW-1:0] GCNT_RELOAD = GW'(GUARD_CYCLES - 1);

  scan_state_t   state;
  scan_state_t   nextState;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic [1:0]    idx;
  logic [3:0]    digits [NUM_DIGITS];
  logic [6:0]    decSeg;
  logic          cntDone;
  logic          gcntDone;
  logic          lit;

  assign cntDone  = (cnt == '0);
  assign gcntDone = (gcnt == '0);

  // State register; reset abandons any slot in progress and restarts on digit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ACTIVE;
    else       state <= nextState;
  end

  // Next state: leave ACTIVE when the lit time expires, leave BLANK when the guard expires
  always_comb begin
    nextState = state;
    if (en) begin
      unique case (state)
        ST_ACTIVE: if (cntDone)  nextState = ST_BLANK;
        ST_BLANK:  if (gcntDone) nextState = ST_ACTIVE;
      endcase
    end
  end

  // Slot timers and digit index; everything freezes while en is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= CNT_RELOAD;
      gcnt <= '0;
      idx  <= '0;
    end else if (en) begin
      unique case (state)
        ST_ACTIVE: begin
          if (cntDone) begin
            cnt  <= CNT_RELOAD;
            gcnt <= GCNT_RELOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_BLANK: begin
          if (gcntDone) idx <= idx + 1'b1;
          else          gcnt <= gcnt - 1'b1;
        end
      endcase
    end
  end

  // Digit register file; writes land in any state, independent of scanning
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
    end else if (wr_en) begin
      digits[wr_addr] <= wr_data;
    end
  end

  hex_decoder u_decoder (
    .value(digits[idx]),
    .seg  (decSeg)
  );

  // Outputs: segment and digit enables share one lit condition so they can never disagree
  always_comb begin
    lit       = en && (state == ST_ACTIVE);
    digit_sel = lit ? (4'b0001 << idx) : 4'b0000;
    seg       = lit ? decSeg : SEG_BLANK;
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: the driver predicts outputs from a
// scan-position model and queues them; the monitor compares every cycle.
module tb_hex_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DIV + GUARD;
  localparam int SCAN  = 4 * SLOT;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] sel;
  } exp_t;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       en      = 1'b1;
  logic       wr_en   = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [6:0] seg;
  logic [3:0] digit_sel;

  exp_t       expQ[$];
  int         checkCount = 0;
  int         passCount  = 0;
  int         pos        = 0;
  logic [3:0] modelDigits [4];
  logic [6:0] glyphTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_scan_ctrl #(
    .DIV_COUNT   (DIV),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .seg      (seg),
    .digit_sel(digit_sel)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Count one comparison and report it when it does not hold
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Expected outputs from the position within a 24-cycle scan and the current enable
  function automatic exp_t modelOutputs();
    exp_t e;
    int   slot;
    bit   litNow;
    slot   = pos / SLOT;
    litNow = en && ((pos % SLOT) < DIV);
    e.sel  = litNow ? 4'(1 << slot) : 4'b0000;
    e.seg  = litNow ? glyphTab[modelDigits[slot]] : 7'h7F;
    return e;
  endfunction

  // Model of what one rising edge does with the inputs held across it
  task automatic modelEdge();
    if (reset) begin
      pos = 0;
      for (int i = 0; i < 4; i++) modelDigits[i] = '0;
    end else begin
      if (wr_en) modelDigits[wr_addr] = wr_data;
      if (en) pos = (pos + 1) % SCAN;
    end
  endtask

  // One cycle: advance the model past the edge, drive new inputs, queue the prediction
  task automatic applyStimulus(input logic rstV, input logic enV, input logic wrV,
                               input logic [1:0] addrV, input logic [3:0] dataV);
    @(posedge clk);
    #1;
    modelEdge();
    reset   = rstV;
    en      = enV;
    wr_en   = wrV;
    wr_addr = addrV;
    wr_data = dataV;
    if (rstV) begin
      pos = 0;
      for (int i = 0; i < 4; i++) modelDigits[i] = '0;
    end
    expQ.push_back(modelOutputs());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
  endtask

  task automatic idleUntil(input int target);
    for (int k = 0; k < SCAN + 2 && pos != target; k++) idle(1);
  endtask

  // Monitor: every cycle check the invariants, and compare against the next queued prediction
  always @(negedge clk) begin
    exp_t e;
    checkOutput("digit_sel_onehot0", 32'($onehot0(digit_sel)), 32'd1);
    checkOutput("sel_seg_agree", 32'((digit_sel != 4'b0000) == (seg != 7'h7F)), 32'd1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("seg", 32'(seg), 32'(e.seg));
      checkOutput("digit_sel", 32'(digit_sel), 32'(e.sel));
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    for (int i = 0; i < 4; i++) modelDigits[i] = '0;

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    idle(26);

    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd1, 4'h8);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 4'hA);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 4'hF);
    idle(30);

    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    idleUntil(0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 4'h8);
    idle(10);

    idleUntil(2 * SLOT + 1);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    idle(10);

    applyStimulus(1'b0, 1'b1, 1'b1, 2'd3, 4'hC);
    idleUntil(3 * SLOT + DIV);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
    idle(10);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)));
    end
    idle(2);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
